// File: rtl/secded_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : secded_scrubber
// Purpose  : Background walker that reads every 39-bit SECDED codeword,
//            corrects single-bit errors in place and counts uncorrectable ones.
// Revision : 1.0 - initial release
// ============================================================================
module secded_scrubber #(
    parameter int ADDR_W   = 12,
    parameter int INTERVAL = 1024
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              scrub_en,
    input  logic              mem_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [38:0]       mem_wdata,
    input  logic [38:0]       mem_rdata,
    output logic [15:0]       scrub_single_cnt,
    output logic [15:0]       scrub_double_cnt,
    output logic [ADDR_W-1:0] scrub_err_addr,
    output logic              scrub_pass_done,
    output logic              scrub_busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_CHK  = 3'd4,
        S_WB   = 3'd5,
        S_NEXT = 3'd6
    } state_t;

    // Last WAIT count value before moving on; zero interval still spends one cycle.
    localparam logic [15:0] c_wait_last = (INTERVAL == 0) ? 16'd0 : 16'(INTERVAL - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_wait_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [38:0]         r_cap;
    logic [15:0]         r_single_cnt;
    logic [15:0]         r_double_cnt;
    logic [ADDR_W-1:0]   r_err_addr;

    logic [5:0]          w_syn;
    logic                w_ovr;
    logic                w_single;
    logic                w_double;
    logic [5:0]          w_pos;
    logic [38:0]         w_fix;
    logic                w_wait_done;

    // Syndrome bit k covers every position whose 1-based index has bit k set.
    always_comb begin
        w_syn = 6'd0;
        for (int i = 0; i < 38; i++) begin
            for (int k = 0; k < 6; k++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    w_syn[k] = w_syn[k] ^ r_cap[i];
                end
            end
        end
    end

    assign w_ovr       = ^r_cap;
    assign w_single    = w_ovr && (w_syn <= 6'd38);
    assign w_double    = (w_ovr && (w_syn > 6'd38)) || (!w_ovr && (w_syn != 6'd0));
    assign w_pos       = (w_syn == 6'd0) ? 6'd38 : (w_syn - 6'd1);
    assign w_fix       = r_cap ^ (39'd1 << w_pos);
    assign w_wait_done = (r_wait_cnt >= c_wait_last);

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        case (r_state)
            S_IDLE: if (scrub_en) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!scrub_en)        w_state_nxt = S_IDLE;
                else if (w_wait_done) w_state_nxt = S_RD;
            end
            S_RD: begin
                mem_req = 1'b1;
                if (!mem_busy) w_state_nxt = S_CAP;
            end
            S_CAP:  w_state_nxt = S_CHK;
            S_CHK:  w_state_nxt = w_single ? S_WB : S_NEXT;
            S_WB: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (!mem_busy) w_state_nxt = S_NEXT;
            end
            S_NEXT: w_state_nxt = scrub_en ? S_WAIT : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_wait_cnt   <= 16'd0;
            r_addr       <= '0;
            r_cap        <= 39'd0;
            r_single_cnt <= 16'd0;
            r_double_cnt <= 16'd0;
            r_err_addr   <= '0;
        end else begin
            if (r_state != S_WAIT) begin
                r_wait_cnt <= 16'd0;
            end else if (!w_wait_done) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end

            if (r_state == S_CAP) begin
                r_cap <= mem_rdata;
            end

            // The corrected word replaces the capture so WB drives it directly.
            if (r_state == S_CHK) begin
                if (w_single) begin
                    r_cap      <= w_fix;
                    r_err_addr <= r_addr;
                    if (r_single_cnt != 16'hFFFF) r_single_cnt <= r_single_cnt + 16'd1;
                end else if (w_double) begin
                    r_err_addr <= r_addr;
                    if (r_double_cnt != 16'hFFFF) r_double_cnt <= r_double_cnt + 16'd1;
                end
            end

            if (r_state == S_NEXT) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign mem_addr         = r_addr;
    assign mem_wdata        = r_cap;
    assign scrub_single_cnt = r_single_cnt;
    assign scrub_double_cnt = r_double_cnt;
    assign scrub_err_addr   = r_err_addr;
    assign scrub_pass_done  = (r_state == S_NEXT) && (&r_addr);
    assign scrub_busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/secded_scrubber.md
SECDED_SCRUBBER -- requirements
Module: secded_scrubber

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the codeword address width (memory depth 2^ADDR_W words).
REQ-002 SHALL have parameter INTERVAL, default 1024, meaning idle cycles between word scrubs (16-bit, value 0 means no wait).
REQ-003 SHALL have ports: mclk  in  1  clock; one clock, all logic on rising edge.
REQ-004 SHALL have ports: puc_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: scrub_en  in  1  enables scrubbing walk.
REQ-006 SHALL have ports: mem_busy  in  1  core owns memory this cycle; scrubber request not accepted.
REQ-007 SHALL have ports: mem_req  out  1  scrubber memory request.
REQ-008 SHALL have ports: mem_we  out  1  request is write (1) or read (0).
REQ-009 SHALL have ports: mem_addr  out  ADDR_W  request address.
REQ-010 SHALL have ports: mem_wdata  out  39  write-back codeword.
REQ-011 SHALL have ports: mem_rdata  in  39  read codeword, valid cycle after read acceptance.
REQ-012 SHALL have ports: scrub_single_cnt  out  16  corrected-error count; scrub_double_cnt  out  16  uncorrectable count.
REQ-013 SHALL have ports: scrub_err_addr  out  ADDR_W  address of last error; scrub_pass_done  out  1  one-cycle pulse per full pass; scrub_busy  out  1  high in every non-IDLE state.

Function
REQ-014 SHALL use the 39-bit SECDED layout: Hamming parity P0..P5 at bit positions 0,1,3,7,15,31; data D0..D31 at remaining positions 2..37 in ascending order; overall parity P6 at bit 38.
REQ-015 SHALL compute syndrome s[5:0] where bit k = XOR of all codeword bits [0..37] whose (index+1) has bit k set; overall o = XOR of all 39 bits.
REQ-016 SHALL classify: o=0,s=0 clean; o=1,s in 1..38 single, flip bit s-1; o=1,s=0 single, flip bit 38; o=1,s>38 double; o=0,s!=0 double.
REQ-017 SHALL implement FSM states IDLE, WAIT, RD, CAP, CHK, WB, NEXT.
REQ-018 IDLE -> WAIT when scrub_en=1; WAIT counts INTERVAL cycles (0: one cycle) then -> RD.
REQ-019 Request accepted in a cycle where mem_req=1 and mem_busy=0; mem_req, mem_we, mem_addr, mem_wdata SHALL be held stable until acceptance.
REQ-020 RD: mem_req=1, mem_we=0; on acceptance -> CAP; CAP registers mem_rdata -> CHK.
REQ-021 CHK (one cycle): clean -> NEXT; single -> increment single count, load scrub_err_addr, -> WB; double -> increment double count, load scrub_err_addr, -> NEXT, no write.
REQ-022 WB: mem_req=1, mem_we=1, mem_wdata = captured codeword with one flipped bit; on acceptance -> NEXT.
REQ-023 Read-acceptance to write-back request SHALL be exactly 3 cycles when mem_busy=0.
REQ-024 NEXT: address increments; wrap from 2^ADDR_W-1 to 0 with scrub_pass_done=1 for that one cycle; -> WAIT if scrub_en=1 else IDLE.
REQ-025 scrub_en deassert mid-word SHALL complete the current word, including write-back, then go to IDLE; address retained for resume.
REQ-026 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-027 mem_req SHALL be 0 in IDLE, WAIT, CAP, CHK, NEXT.

Reset
REQ-028 puc_rst=1 at a rising edge SHALL force IDLE, address 0, interval counter 0, both counters 0, scrub_err_addr 0, captured word 0, all outputs 0, from any state including mid-request.
REQ-029 puc_rst SHALL take priority over scrub_en and over any pending acceptance in the same cycle.

Verification
REQ-030 INTERVAL=0, ADDR_W=2, all words 39'h0, mem_busy=0 -> four reads addr 0..3, no writes, scrub_pass_done pulse after addr 3, counts 0.
REQ-031 addr 1 holds 39'h4 (D0 flipped) -> s=3, o=1, write 39'h0 to addr 1 exactly 3 cycles after read accepted, single_cnt=1, scrub_err_addr=1.
REQ-032 addr 2 holds 39'h6 -> s=1, o=0, double_cnt=1, scrub_err_addr=2, no write issued.
REQ-033 addr 0 holds 39'h40_0000_0000 -> single, write 39'h0; separate word with s=63,o=1 -> counted double.
REQ-034 mem_busy held 1 for 5 cycles during RD and WB -> requests held stable, single acceptance each; INTERVAL=4 -> 4 WAIT cycles between words.
REQ-035 puc_rst asserted during WB -> next edge mem_req=0, state IDLE, counters 0; counter preloaded near 16'hFFFF stays at 16'hFFFF on further errors.
